// File: rtl/uart_pkg.sv
// Shared types and defaults for the MiniUart transmit scheduler.
package uart_pkg;

  // Width of one transmitted byte.
  localparam int BYTE_W = 8;

  // 434 cycles per bit gives 115200 baud from a 50 MHz clock.
  localparam int BAUD_DIV_DEF = 434;

  // Byte FIFO entries; must be a power of two so the pointers wrap naturally.
  localparam int FIFO_DEPTH_DEF = 4;

  // Load sequencer states; encoding is fixed so debug probes read consistently.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester, transmit-unit and status signals of the transmit scheduler.
interface uart_tx_sched_if #(
  parameter int FIFO_DEPTH = uart_pkg::FIFO_DEPTH_DEF
) ();
  import uart_pkg::*;

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  // CPU bus write port
  logic              req0_valid;
  logic [BYTE_W-1:0] req0_data;
  logic              req0_ready;
  // loop-back / echo port
  logic              req1_valid;
  logic [BYTE_W-1:0] req1_data;
  logic              req1_ready;
  // transmit unit
  logic [BYTE_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_en;
  logic              tx_ts;
  // status
  logic [CNT_W-1:0]  fifo_count;
  logic              busy;

  // Environment side: requesters plus the transmit unit's idle status.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_ts,
    input  req0_ready, req1_ready, tx_data, tx_load, tx_en, fifo_count, busy
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_ts,
    output req0_ready, req1_ready, tx_data, tx_load, tx_en, fifo_count, busy
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with wrap-around pointers and a head word that is
// readable combinationally, so the sequencer can pop straight into its
// tx_data register on the same edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Overflowing or underflowing requests are dropped rather than corrupting state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; a simultaneous push and pop keeps the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any queued bytes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: round-robin arbiter for two byte requesters, byte FIFO,
// free-running baud enable and the load sequencer for the transmit unit.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_sched_if.slave bus
);

  localparam int                CNT_W     = cnt_width(FIFO_DEPTH);
  localparam int                BAUD_W    = 16;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

  // ---------------- arbitration ----------------
  logic [1:0]        req_valid;
  logic [1:0]        grant;
  logic [1:0]        req_ready;
  logic [BYTE_W-1:0] req_data [2];
  logic              last_grant_q, last_grant_d;
  logic              fifo_push;
  logic [BYTE_W-1:0] push_data;
  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [BYTE_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  assign req_valid   = {bus.req1_valid, bus.req0_valid};
  assign req_data[0] = bus.req0_data;
  assign req_data[1] = bus.req1_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // A port wins when it is alone, or when the other port was served last.
      assign grant[gi]     = req_valid[gi] &&
                             (!req_valid[1-gi] || (last_grant_q != 1'(gi)));
      // No bypass: a full FIFO refuses even if a pop happens this cycle.
      assign req_ready[gi] = grant[gi] && !fifo_full;
    end
  endgenerate

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];

  // At most one port is ready, so its data can be selected by that bit alone.
  assign fifo_push = |(req_valid & req_ready);
  assign push_data = req_ready[1] ? req_data[1] : req_data[0];

  // The fairness pointer only moves when a byte is actually taken.
  always_comb begin
    last_grant_d = last_grant_q;
    if (fifo_push) begin
      last_grant_d = req_ready[1];
    end
  end

  // Pointer starts at port 1 so port 0 wins the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // ---------------- byte FIFO ----------------
  uart_tx_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.fifo_count = fifo_count;

  // ---------------- baud enable ----------------
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;

  // Free-running bit-time counter, independent of the sequencer state.
  always_comb begin
    baud_cnt_d = baud_cnt_q + 1'b1;
    if (baud_cnt_q == BAUD_LAST) begin
      baud_cnt_d = '0;
    end
  end

  // Baud counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

  assign bus.tx_en = (baud_cnt_q == BAUD_LAST);

  // ---------------- load sequencer ----------------
  tx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;

  // Pop only into an idle unit, then wait for it to go busy and come back, so
  // one byte can never be loaded twice or overwrite a frame in flight.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && bus.tx_ts) begin
          fifo_pop  = 1'b1;
          tx_data_d = fifo_head;
          state_d   = LOAD;
        end
      end
      LOAD:      state_d = WAIT_BUSY;
      WAIT_BUSY: if (!bus.tx_ts) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_ts) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Sequencer state and the held byte; reset drops tx_load at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.tx_load = (state_q == LOAD);
  assign bus.tx_data = tx_data_q;
  assign bus.busy    = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed and randomized bench for uart_tx_sched with a transmit-unit model
// and a queue-based scoreboard of accepted bytes.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_sched #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // requester queues and knobs
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         rnd_valid = 1'b0;
  bit         acc0 = 1'b0, acc1 = 1'b0;

  // transmit unit model knobs and state
  int drop_dly = 2;
  int busy_len = 5;
  bit hold_low = 1'b0;
  int ph = 0;
  int tmr = 0;
  bit ld_seen = 1'b0;

  // reference model / scoreboard
  logic [7:0] expq[$];
  logic [7:0] loaded[$];
  int         load_cyc[$];
  int         acc_cyc[$];
  int         mcount = 0;
  bit         mlast = 1'b1;
  int         bcnt = 0;
  bit         ts_prev = 1'b1;
  int         cyc = 0;
  bit         er0, er1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  // Drive requesters and the transmit-unit model just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ph             = 0;
      bus.tx_ts      = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end else begin
      if (acc0) void'(q0.pop_front());
      if (acc0 || !bus.req0_valid) begin
        if (q0.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
          bus.req0_valid = 1'b1;
          bus.req0_data  = q0[0];
        end else begin
          bus.req0_valid = 1'b0;
        end
      end
      if (acc1) void'(q1.pop_front());
      if (acc1 || !bus.req1_valid) begin
        if (q1.size() > 0 && (!rnd_valid || $urandom_range(0, 1) == 1)) begin
          bus.req1_valid = 1'b1;
          bus.req1_data  = q1[0];
        end else begin
          bus.req1_valid = 1'b0;
        end
      end
      // unit: idle -> (drop_dly) -> busy for busy_len cycles -> idle
      if (hold_low) begin
        bus.tx_ts = 1'b0;
        ph        = 0;
      end else begin
        if (ld_seen && ph == 0) begin
          ph  = 1;
          tmr = drop_dly;
        end
        if (ph == 1) begin
          tmr--;
          if (tmr <= 0) begin
            bus.tx_ts = 1'b0;
            ph        = 2;
            tmr       = busy_len;
          end
        end else if (ph == 2) begin
          tmr--;
          if (tmr <= 0) begin
            bus.tx_ts = 1'b1;
            ph        = 0;
          end
        end else begin
          bus.tx_ts = 1'b1;
        end
      end
    end
  end

  // Observe on the falling edge and compare against the reference model.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mcount  = 0;
      mlast   = 1'b1;
      bcnt    = 0;
      expq.delete();
      acc0    = 1'b0;
      acc1    = 1'b0;
      ld_seen = 1'b0;
      ts_prev = bus.tx_ts;
    end else begin
      chk("tx_en", 32'(bus.tx_en), 32'(bcnt == BAUD - 1));
      bcnt    = (bcnt + 1) % BAUD;
      ld_seen = bus.tx_load;
      if (bus.tx_load) begin
        chk("load_unit_idle", 32'(ts_prev), 32'd1);
        chk("load_has_byte", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) chk("tx_data", 32'(bus.tx_data), 32'(expq.pop_front()));
        mcount--;
        loaded.push_back(bus.tx_data);
        load_cyc.push_back(cyc);
        $display("load  data=%02h cycle=%0d", bus.tx_data, cyc);
      end
      chk("fifo_count", 32'(bus.fifo_count), 32'(mcount));
      er0 = bus.req0_valid && (!bus.req1_valid || mlast)  && (mcount < DEPTH);
      er1 = bus.req1_valid && (!bus.req0_valid || !mlast) && (mcount < DEPTH);
      if (bus.req0_valid || bus.req1_valid) begin
        chk("req0_ready", 32'(bus.req0_ready), 32'(er0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(er1));
      end
      if (er0) begin
        expq.push_back(bus.req0_data);
        mcount++;
        mlast = 1'b0;
        acc_cyc.push_back(cyc);
        $display("push  port=0 data=%02h cycle=%0d", bus.req0_data, cyc);
      end else if (er1) begin
        expq.push_back(bus.req1_data);
        mcount++;
        mlast = 1'b1;
        acc_cyc.push_back(cyc);
        $display("push  port=1 data=%02h cycle=%0d", bus.req1_data, cyc);
      end
      acc0    = bus.req0_valid && bus.req0_ready;
      acc1    = bus.req1_valid && bus.req1_ready;
      ts_prev = bus.tx_ts;
    end
  end

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while ((q0.size() > 0 || q1.size() > 0 || bus.busy || ph != 0 || !bus.tx_ts)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain_in_time"}, 32'(n < budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    hold_low = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, a0, cnt, nb, tot;
    logic [7:0] rr_exp[4];
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.tx_ts      = 1'b1;
    rst            = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_tx_load", 32'(bus.tx_load), 32'd0);
    chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);

    // round-robin: both ports valid from the same cycle, port 0 first
    n0 = loaded.size();
    drop_dly = 2;
    busy_len = 4;
    q0.push_back(8'h10); q0.push_back(8'h11);
    q1.push_back(8'h20); q1.push_back(8'h21);
    wait_drain("rr", 400);
    rr_exp = '{8'h10, 8'h20, 8'h11, 8'h21};
    chk("rr_loads", 32'(loaded.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++)
      if (loaded.size() > n0 + i) chk("rr_order", 32'(loaded[n0+i]), 32'(rr_exp[i]));

    // single byte latency and baud pulse rate
    n0 = loaded.size();
    a0 = acc_cyc.size();
    drop_dly = 2;
    busy_len = 6;
    q0.push_back(8'hA5);
    wait_drain("single", 200);
    chk("single_loads", 32'(loaded.size() - n0), 32'd1);
    if (loaded.size() > n0) begin
      chk("single_data", 32'(loaded[n0]), 32'hA5);
      chk("single_latency", 32'(load_cyc[n0] - acc_cyc[a0]), 32'd2);
    end
    chk("single_busy_after", 32'(bus.busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.tx_en) cnt++;
    end
    chk("baud_pulses_16", 32'(cnt), 32'd4);

    // full FIFO: unit held busy, 5 bytes offered
    n0 = loaded.size();
    hold_low = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) q0.push_back(8'(8'h30 + i));
    repeat (12) @(negedge clk);
    chk("full_count", 32'(bus.fifo_count), 32'd4);
    chk("full_ready0", 32'(bus.req0_ready), 32'd0);
    chk("full_fifth_held", 32'(q0.size()), 32'd1);
    chk("full_no_load", 32'(loaded.size() - n0), 32'd0);
    drop_dly = 2;
    busy_len = 3;
    hold_low = 1'b0;
    wait_drain("full", 400);
    chk("full_loads", 32'(loaded.size() - n0), 32'd5);
    for (int i = 0; i < 5; i++)
      if (loaded.size() > n0 + i) chk("full_order", 32'(loaded[n0+i]), 32'(8'h30 + i));

    // load spacing with a long busy time
    n0 = loaded.size();
    drop_dly = 2;
    busy_len = 20;
    for (int i = 0; i < 3; i++) q0.push_back(8'(8'h40 + i));
    wait_drain("space", 400);
    chk("space_loads", 32'(loaded.size() - n0), 32'd3);
    for (int i = 1; i < 3; i++)
      if (load_cyc.size() > n0 + i)
        chk("space_gap_ge22", 32'(load_cyc[n0+i] - load_cyc[n0+i-1] >= 22), 32'd1);

    // reset while waiting for the unit to finish, 2 bytes still queued
    do_reset();
    n0 = loaded.size();
    drop_dly = 2;
    busy_len = 40;
    for (int i = 0; i < 3; i++) q0.push_back(8'(8'h50 + i));
    cnt = 0;
    while (!(loaded.size() - n0 == 1 && bus.fifo_count == 2 && !bus.tx_ts) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("midrst_reached", 32'(cnt < 100), 32'd1);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_tx_load", 32'(bus.tx_load), 32'd0);
    chk("midrst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("midrst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("midrst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("midrst_req1_ready", 32'(bus.req1_ready), 32'd0);
    chk("midrst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = loaded.size();
    repeat (30) @(negedge clk);
    chk("midrst_no_load", 32'(loaded.size() - n0), 32'd0);

    // wrap-around: 10 bytes through the 4-entry FIFO
    n0 = loaded.size();
    drop_dly = $urandom_range(1, 3);
    busy_len = $urandom_range(1, 6);
    for (int i = 0; i < 10; i++) q0.push_back(8'(i));
    wait_drain("wrap", 600);
    chk("wrap_loads", 32'(loaded.size() - n0), 32'd10);
    for (int i = 0; i < 10; i++)
      if (loaded.size() > n0 + i) chk("wrap_data", 32'(loaded[n0+i]), 32'(i));

    // randomized traffic on both ports with random valid gaps
    rnd_valid = 1'b1;
    for (int r = 0; r < 4; r++) begin
      n0 = loaded.size();
      drop_dly = $urandom_range(1, 3);
      busy_len = $urandom_range(1, 8);
      nb = $urandom_range(3, 8);
      for (int i = 0; i < nb; i++) q0.push_back(8'($urandom));
      tot = nb;
      nb = $urandom_range(3, 8);
      for (int i = 0; i < nb; i++) q1.push_back(8'($urandom));
      tot += nb;
      wait_drain("rand", 1500);
      chk("rand_loads", 32'(loaded.size() - n0), 32'(tot));
    end
    rnd_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
